fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the RichieJr 8-bit CPU.
- Owns the program counter and issues byte reads to instruction memory through a ready handshake.
- Delivers each fetched byte as data plus a one-cycle load strobe to the downstream 8-bit instruction register (drives its data_In/en).
- Supports stall and branch redirect from the control path.

Parameters:
- ADDR_W, 8, program counter / memory address width.
- DATA_W, 8, instruction byte width.
- RESET_PC, 8'h00, PC value loaded on reset.
- TIMEOUT_CYCLES, 15, REQ cycles without mem_ready before fault (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset; asynchronous assert, active-low (res=0 resets).
- stall  in  1  hold fetch; sampled in IDLE and DONE only.
- branch_take  in  1  redirect PC this cycle.
- branch_target  in  ADDR_W  new PC when branch_take=1.
- mem_addr  out  ADDR_W  read address; always equals pc.
- mem_rd  out  1  read request; high for the whole REQ state.
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1.
- mem_ready  in  1  read complete; ignored unless mem_rd=1.
- ir_data  out  DATA_W  fetched byte, registered.
- ir_en  out  1  one-cycle load strobe for the instruction register.
- pc  out  ADDR_W  current program counter.
- fault  out  1  fetch timeout flag; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (res=0, asynchronous): state=IDLE, pc=RESET_PC, ir_data=0, mem_rd=0, ir_en=0, fault=0.
- Reset release is sampled synchronously; the first REQ is no earlier than the first clk edge after res=1.
- States are one-hot: IDLE, REQ, DONE, plus FAULT with the option. mem_rd=(state==REQ) and ir_en=(state==DONE), both decoded from registered state.
- IDLE:
  - branch_take → pc<=branch_target.
  - stall=0 → REQ, otherwise remain in IDLE.
- REQ:
  - branch_take=1 → abort: pc<=branch_target, go to IDLE, drop any concurrent mem_rdata, no ir_en.
  - Otherwise, mem_ready=1 → ir_data<=mem_rdata, pc<=pc+1 modulo 2^ADDR_W (8'hFF wraps to 8'h00), go to DONE.
  - stall is ignored while in REQ.
- DONE:
  - ir_en=1 for exactly this cycle; ir_data holds the new byte.
  - branch_take → pc<=branch_target, go to IDLE.
  - Else stall=1 → IDLE; else → REQ.
- Latency: mem_ready sampled high → ir_en high on the next cycle.
- Zero-wait memory gives one byte every 2 cycles.
- branch_take and mem_ready in the same cycle: branch wins.
- ir_data holds its value between strobes; it changes only on REQ→DONE.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears on REQ entry and increments each REQ cycle with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES, go to FAULT: mem_rd=0, fault=1 (sticky), pc frozen.
  - FAULT ignores branch_take and stall; it exits only on reset.
- Undefined: no counter, no FAULT state, fault tied to 0, REQ waits forever.

Decomposition:
- Package richie_jr_pkg: ADDR_W/DATA_W constants, RESET_PC default, fetch state enum/one-hot encodings.
- Sub-module pc_counter: ADDR_W register with async active-low res, load (branch) priority over increment, and wrap.
- The FSM and handshake live in fetch_unit.

Test Plan:
- Reset, then res=1, stall=0, memory returns 8'h69 at addr 0 with mem_ready same cycle as mem_rd → ir_en pulses 1 cycle later with ir_data=8'h69, pc=8'h01; next mem_rd 1 cycle after ir_en.
- Memory with 3 wait cycles at addr 5 returning 8'hF8 → mem_rd held 4 cycles, mem_addr=8'h05 stable, single ir_en, pc=8'h06.
- branch_take with branch_target=8'h40 in the same cycle as mem_ready → no ir_en, next mem_addr=8'h40.
- pc=8'hFF fetch completes → pc wraps to 8'h00; stall=1 asserted during DONE → IDLE, mem_rd low until stall=0.
- res pulled low mid-REQ → mem_rd, ir_en, ir_data drop to 0 immediately (asynchronous), pc=RESET_PC.
- With FETCH_TIMEOUT_EN: mem_ready held 0 for 15 REQ cycles → fault=1, mem_rd=0, remains so until res=0.

Source files
------------

// File: rtl/richie_jr_pkg.sv
// Shared constants and fetch-state encodings for the RichieJr 8-bit CPU.
package richie_jr_pkg;

    localparam int RJ_ADDR_W = 8;
    localparam int RJ_DATA_W = 8;
    localparam logic [RJ_ADDR_W-1:0] RJ_RESET_PC = 8'h00;
    localparam int RJ_TIMEOUT_CYCLES = 15;

    // One-hot fetch states; FETCH_FAULT is only reachable when the timeout
    // option is built in.
    typedef enum logic [3:0] {
        FETCH_IDLE  = 4'b0001,
        FETCH_REQ   = 4'b0010,
        FETCH_DONE  = 4'b0100,
        FETCH_FAULT = 4'b1000
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: branch load has priority over increment,
// and the increment wraps naturally at 2^ADDR_W.
module pc_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              res,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // PC update: async active-low reset, then load, then increment.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the RichieJr CPU: owns the PC, issues byte
// reads with a ready handshake and strobes each byte into the IR.
// Optional feature: define FETCH_TIMEOUT_EN to enable the memory wait
// timeout and the sticky FAULT state.
module fetch_unit
    import richie_jr_pkg::*;
#(
    parameter int                ADDR_W         = RJ_ADDR_W,
    parameter int                DATA_W         = RJ_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC       = RJ_RESET_PC,
    parameter int                TIMEOUT_CYCLES = RJ_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              res,
    input  logic              stall,
    input  logic              branch_take,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir_data,
    output logic              ir_en,
    output logic [ADDR_W-1:0] pc,
    output logic              fault
);

    fetch_state_t state;
    logic         pc_load;
    logic         pc_inc;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign fault          = 1'b0;
`endif

    // Handshake and IR strobe are pure decodes of the registered state.
    assign mem_rd   = (state == FETCH_REQ);
    assign ir_en    = (state == FETCH_DONE);
    assign mem_addr = pc;

    // Branches redirect in every live state; a branch during REQ also
    // suppresses the increment so a concurrent mem_ready is dropped.
    assign pc_load = branch_take && ((state == FETCH_IDLE) ||
                                     (state == FETCH_REQ)  ||
                                     (state == FETCH_DONE));
    assign pc_inc  = (state == FETCH_REQ) && mem_ready && !branch_take;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .res        (res),
        .load       (pc_load),
        .load_value (branch_target),
        .inc        (pc_inc),
        .pc         (pc)
    );

    // Fetch FSM with the IR byte register (and timeout tracking if built in).
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state   <= FETCH_IDLE;
            ir_data <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
            fault    <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (!stall) begin
                        state <= FETCH_REQ;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                FETCH_REQ: begin
                    if (branch_take) begin
                        state <= FETCH_IDLE;
                    end else if (mem_ready) begin
                        ir_data <= mem_rdata;
                        state   <= FETCH_DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        state <= FETCH_FAULT;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`endif
                end
                FETCH_DONE: begin
                    if (branch_take || stall) begin
                        state <= FETCH_IDLE;
                    end else begin
                        state <= FETCH_REQ;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                FETCH_FAULT: begin
                    state <= FETCH_FAULT;
                end
`endif
                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors, a wait-state memory
// model and a scoreboard that checks every ir_en strobe.
// Define FETCH_TIMEOUT_EN to also exercise the timeout/FAULT behaviour.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       res;
    logic       stall;
    logic       branch_take;
    logic [7:0] branch_target;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic [7:0] ir_data;
    logic       ir_en;
    logic [7:0] pc;
    logic       fault;

    logic [7:0] mem [256];
    int         mem_wait   = 0;
    int         req_cycles = 0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    fetch_unit dut (
        .clk           (clk),
        .res           (res),
        .stall         (stall),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .ir_data       (ir_data),
        .ir_en         (ir_en),
        .pc            (pc),
        .fault         (fault)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Memory model: answers after mem_wait cycles of continuous mem_rd.
    assign mem_ready = mem_rd && (req_cycles >= mem_wait);
    assign mem_rdata = mem[mem_addr];

    // Count how long the current read has been outstanding.
    always @(posedge clk) begin
        if (!mem_rd || mem_ready) req_cycles <= 0;
        else                      req_cycles <= req_cycles + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic b, input logic [7:0] t);
        stall         = s;
        branch_take   = b;
        branch_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpect(input logic [7:0] d, input logic [7:0] p);
        exp_t e;
        e.data = d;
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every IR strobe must match the next expected byte.
    always @(negedge clk) begin
        exp_t e;
        if (res === 1'b1 && ir_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL sb_unexpected_strobe: got ir_data 0x%0h pc 0x%0h, expected no strobe",
                         ir_data, pc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_ir_data", 32'(ir_data), 32'(e.data));
                checkOutput("sb_pc", 32'(pc), 32'(e.pc));
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h69;
        mem[8'h01] = 8'hA2;
        mem[8'h05] = 8'hF8;
        mem[8'h06] = 8'h11;
        mem[8'h40] = 8'h3C;
        mem[8'hFF] = 8'hC7;

        res           = 1'b0;
        stall         = 1'b1;
        branch_take   = 1'b0;
        branch_target = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pc", 32'(pc), 32'h00);
        checkOutput("reset_mem_rd", 32'(mem_rd), 32'h0);
        checkOutput("reset_ir_en", 32'(ir_en), 32'h0);
        checkOutput("reset_ir_data", 32'(ir_data), 32'h00);
        checkOutput("reset_fault", 32'(fault), 32'h0);

        // Zero-wait fetch of addr 0, then back-to-back fetch of addr 1.
        res = 1'b1;
        #1;
        checkOutput("release_mem_rd", 32'(mem_rd), 32'h0);
        pushExpect(8'h69, 8'h01);
        pushExpect(8'hA2, 8'h02);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("a_req_rd", 32'(mem_rd), 32'h1);
        checkOutput("a_req_addr", 32'(mem_addr), 32'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("a_done_en", 32'(ir_en), 32'h1);
        checkOutput("a_done_pc", 32'(pc), 32'h01);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("a_next_rd", 32'(mem_rd), 32'h1);
        checkOutput("a_next_addr", 32'(mem_addr), 32'h01);
        checkOutput("a_next_en", 32'(ir_en), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("a_done2_en", 32'(ir_en), 32'h1);
        checkOutput("a_done2_pc", 32'(pc), 32'h02);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("a_idle_rd", 32'(mem_rd), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("a_stall_rd", 32'(mem_rd), 32'h0);

        // Branch in IDLE to addr 5, then a fetch with 3 wait cycles.
        applyStimulus(1'b1, 1'b1, 8'h05);
        checkOutput("b_branch_pc", 32'(pc), 32'h05);
        checkOutput("b_branch_rd", 32'(mem_rd), 32'h0);
        mem_wait = 3;
        pushExpect(8'hF8, 8'h06);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("b_req1_rd", 32'(mem_rd), 32'h1);
        checkOutput("b_req1_addr", 32'(mem_addr), 32'h05);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            checkOutput($sformatf("b_req%0d_rd", k), 32'(mem_rd), 32'h1);
            checkOutput($sformatf("b_req%0d_addr", k), 32'(mem_addr), 32'h05);
            checkOutput($sformatf("b_req%0d_en", k), 32'(ir_en), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("b_done_en", 32'(ir_en), 32'h1);
        checkOutput("b_done_pc", 32'(pc), 32'h06);
        checkOutput("b_done_rd", 32'(mem_rd), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("b_single_en", 32'(ir_en), 32'h0);

        // Branch wins over a concurrent mem_ready.
        mem_wait = 0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("c_req_addr", 32'(mem_addr), 32'h06);
        applyStimulus(1'b1, 1'b1, 8'h40);
        checkOutput("c_abort_en", 32'(ir_en), 32'h0);
        checkOutput("c_abort_rd", 32'(mem_rd), 32'h0);
        checkOutput("c_abort_pc", 32'(pc), 32'h40);
        checkOutput("c_hold_ir_data", 32'(ir_data), 32'hF8);
        pushExpect(8'h3C, 8'h41);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("c_redirect_addr", 32'(mem_addr), 32'h40);
        checkOutput("c_redirect_rd", 32'(mem_rd), 32'h1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("c_done_pc", 32'(pc), 32'h41);
        applyStimulus(1'b1, 1'b0, 8'h00);

        // PC wrap from 8'hFF, then stall during DONE parks the unit in IDLE.
        applyStimulus(1'b1, 1'b1, 8'hFF);
        pushExpect(8'hC7, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("d_req_addr", 32'(mem_addr), 32'hFF);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("d_wrap_pc", 32'(pc), 32'h00);
        checkOutput("d_wrap_en", 32'(ir_en), 32'h1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("d_stall_rd1", 32'(mem_rd), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("d_stall_rd2", 32'(mem_rd), 32'h0);

        // Asynchronous reset in the middle of a REQ.
        mem_wait = 20;
        applyStimulus(1'b0, 1'b1, 8'h80);
        checkOutput("e_req_rd", 32'(mem_rd), 32'h1);
        checkOutput("e_req_addr", 32'(mem_addr), 32'h80);
        #2;
        res = 1'b0;
        #1;
        checkOutput("e_async_rd", 32'(mem_rd), 32'h0);
        checkOutput("e_async_en", 32'(ir_en), 32'h0);
        checkOutput("e_async_ir_data", 32'(ir_data), 32'h00);
        checkOutput("e_async_pc", 32'(pc), 32'h00);
        checkOutput("e_async_fault", 32'(fault), 32'h0);
        stall       = 1'b1;
        branch_take = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b1;

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: FAULT after 15 waiting REQ cycles, sticky.
        mem_wait = 1000;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("f_req_rd", 32'(mem_rd), 32'h1);
        repeat (14) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("f_pre_fault", 32'(fault), 32'h0);
        checkOutput("f_pre_rd", 32'(mem_rd), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("f_fault", 32'(fault), 32'h1);
        checkOutput("f_fault_rd", 32'(mem_rd), 32'h0);
        repeat (2) applyStimulus(1'b0, 1'b1, 8'h22);
        checkOutput("f_sticky_fault", 32'(fault), 32'h1);
        checkOutput("f_sticky_rd", 32'(mem_rd), 32'h0);
        checkOutput("f_frozen_pc", 32'(pc), 32'h00);
        checkOutput("f_sticky_en", 32'(ir_en), 32'h0);
        res = 1'b0;
        #1;
        checkOutput("f_reset_fault", 32'(fault), 32'h0);
        res = 1'b1;
`endif

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
